// File: rtl/enum_stream_decoder_pkg.sv
// Shared types for the byte-wide enumeration stream: enum members, raw code views,
// buffer payload and state encoding, plus the legality check used by the decoder.
package pkg;

  typedef enum logic [7:0] {
    ONE   = 8'd0,
    TWO   = 8'd1,
    THREE = 8'd2
  } enum_t;

  // Typed value as delivered downstream; 8 bits wide so a forwarded illegal code survives intact.
  typedef logic [7:0] alias_t;

  // Raw code as seen on the byte link.
  typedef logic [7:0] third_alias_t;

  localparam third_alias_t ENUM_NUM_CODES = 8'd3;

  typedef struct packed {
    logic   illegal;
    alias_t data;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  function automatic logic is_legal_code(input third_alias_t code);
    return (code < ENUM_NUM_CODES);
  endfunction

endpackage

// File: rtl/enum_skid_buf.sv
// Two-entry elastic valid/ready buffer for decoded payloads.
// The head register drives the output directly; the tail only holds data while FULL.
module enum_skid_buf
  import pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_valid,
  output logic     push_ready,
  input  payload_t push_data,
  output logic     pop_valid,
  input  logic     pop_ready,
  output payload_t pop_data
);

  buf_state_t state_q, state_d;
  payload_t   head_q, tail_q;
  logic       push, pop;

  // Readiness depends only on the state register, so there is no path from pop_ready.
  assign push_ready = (state_q != FULL);
  assign pop_valid  = (state_q != EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = head_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = HALF;
      HALF: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = HALF;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        EMPTY: if (push) head_q <= push_data;
        HALF: begin
          if (push && pop) head_q <= push_data;
          else if (push)   tail_q <= push_data;
        end
        FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/enum_stream_decoder.sv
// Receive-side decoder: legality check of raw enum codes, error status, 2-entry output buffer.
// Optional macro ENUM_STREAM_DECODER_ERR_CNT_EN enables the saturating illegal-code counter.
module enum_stream_decoder
  import pkg::*;
#(
  parameter bit          DROP_ILLEGAL = 1'b1,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  third_alias_t         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output alias_t               out_data,
  output logic                 out_illegal,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic     code_legal;
  logic     in_accept;
  logic     illegal_acc;
  logic     push_valid;
  payload_t push_data;
  payload_t pop_data;

  assign code_legal  = is_legal_code(in_data);
  assign in_accept   = in_valid && in_ready;
  assign illegal_acc = in_accept && !code_legal;
  // Dropped codes still complete the handshake via in_ready but never reach the buffer.
  assign push_valid  = in_valid && (code_legal || !DROP_ILLEGAL);

  always_comb begin
    push_data         = '0;
    push_data.illegal = !code_legal;
    push_data.data    = in_data;
  end

  enum_skid_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (in_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign out_data    = pop_data.data;
  assign out_illegal = pop_data.illegal;

  logic err_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_sticky_q <= 1'b0;
    else if (err_clr)     err_sticky_q <= illegal_acc;
    else if (illegal_acc) err_sticky_q <= 1'b1;
  end

  assign err_sticky = err_sticky_q;

`ifdef ENUM_STREAM_DECODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // A clear coinciding with an accepted illegal code restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= illegal_acc ? ERR_CNT_W'(1) : '0;
    end else if (illegal_acc && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_enum_stream_decoder.sv
// Directed bench for enum_stream_decoder: three instances (drop, forward, 2-bit counter) share stimulus.
module tb_enum_stream_decoder;

`ifdef ENUM_STREAM_DECODER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       err_clr;

  logic        in_ready_d, out_valid_d, out_illegal_d, err_sticky_d;
  logic [7:0]  out_data_d;
  logic [15:0] err_cnt_d;

  logic        in_ready_f, out_valid_f, out_illegal_f, err_sticky_f;
  logic [7:0]  out_data_f;
  logic [15:0] err_cnt_f;

  logic        in_ready_s, out_valid_s, out_illegal_s, err_sticky_s;
  logic [7:0]  out_data_s;
  logic [1:0]  err_cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enum_stream_decoder #(.DROP_ILLEGAL(1'b1), .ERR_CNT_W(16)) d_drop (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
    .out_illegal(out_illegal_d), .err_clr(err_clr), .err_sticky(err_sticky_d), .err_cnt(err_cnt_d)
  );

  enum_stream_decoder #(.DROP_ILLEGAL(1'b0), .ERR_CNT_W(16)) d_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f), .in_data(in_data),
    .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
    .out_illegal(out_illegal_f), .err_clr(err_clr), .err_sticky(err_sticky_f), .err_cnt(err_cnt_f)
  );

  enum_stream_decoder #(.DROP_ILLEGAL(1'b1), .ERR_CNT_W(2)) d_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_illegal(out_illegal_s), .err_clr(err_clr), .err_sticky(err_sticky_s), .err_cnt(err_cnt_s)
  );

  function automatic logic [31:0] cexp(input int unsigned v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  sat_codes [5];
  int unsigned sat_exp   [5];

  initial begin
    sat_codes = '{8'h03, 8'h04, 8'h80, 8'hFE, 8'h10};
    sat_exp   = '{1, 2, 3, 3, 3};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_in_ready",   32'(in_ready_d),    1);
    chk("rst_out_valid",  32'(out_valid_d),   0);
    chk("rst_out_data",   32'(out_data_d),    0);
    chk("rst_out_ill",    32'(out_illegal_f), 0);
    chk("rst_sticky",     32'(err_sticky_d),  0);
    chk("rst_cnt",        32'(err_cnt_d),     0);
    rst_n = 1'b1;
    tick();

    // Legal stream 0,1,2 with one-cycle latency at full rate
    in_valid = 1'b1; in_data = 8'd0;
    tick();
    chk("s1_valid0", 32'(out_valid_d), 1);
    chk("s1_data0",  32'(out_data_d),  0);
    in_data = 8'd1;
    tick();
    chk("s1_data1",  32'(out_data_d),  1);
    chk("s1_rdy1",   32'(in_ready_d),  1);
    in_data = 8'd2;
    tick();
    chk("s1_data2",  32'(out_data_d),  2);
    chk("s1_ill2",   32'(out_illegal_d), 0);
    in_valid = 1'b0;
    tick();
    chk("s1_empty",  32'(out_valid_d), 0);
    chk("s1_cnt",    32'(err_cnt_d),   0);
    chk("s1_sticky", 32'(err_sticky_d), 0);

    // Backpressure: two accepted, third held until release
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd0;
    tick();
    chk("bp_rdy_half", 32'(in_ready_d), 1);
    in_data = 8'd1;
    tick();
    chk("bp_rdy_full", 32'(in_ready_d), 0);
    chk("bp_head0",    32'(out_data_d), 0);
    in_data = 8'd2;
    tick();
    chk("bp_held_rdy",  32'(in_ready_d), 0);
    chk("bp_held_data", 32'(out_data_d), 0);
    out_ready = 1'b1;
    tick();
    chk("bp_out1",  32'(out_data_d), 1);
    chk("bp_rdy_r", 32'(in_ready_d), 1);
    tick();
    chk("bp_out2",  32'(out_data_d), 2);
    chk("bp_v2",    32'(out_valid_d), 1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", 32'(out_valid_d), 0);

    // Stream 1,0x07,2: dropped vs forwarded
    in_valid = 1'b1; in_data = 8'd1;
    tick();
    chk("ill_d_out1", 32'(out_data_d), 1);
    in_data = 8'h07;
    tick();
    chk("ill_d_gap",    32'(out_valid_d),   0);
    chk("ill_f_data",   32'(out_data_f),    'h07);
    chk("ill_f_flag",   32'(out_illegal_f), 1);
    chk("ill_d_sticky", 32'(err_sticky_d),  1);
    chk("ill_d_cnt",    32'(err_cnt_d),     cexp(1));
    in_data = 8'd2;
    tick();
    chk("ill_d_out2",  32'(out_data_d),    2);
    chk("ill_d_v2",    32'(out_valid_d),   1);
    chk("ill_f_flag2", 32'(out_illegal_f), 0);
    in_valid = 1'b0;
    tick();
    chk("ill_d_empty", 32'(out_valid_d), 0);

    // Clear then forward 0xFF
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_sticky", 32'(err_sticky_f), 0);
    chk("clr_cnt",    32'(err_cnt_f),    0);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    chk("ff_f_data",   32'(out_data_f),    'hFF);
    chk("ff_f_flag",   32'(out_illegal_f), 1);
    chk("ff_f_valid",  32'(out_valid_f),   1);
    chk("ff_f_cnt",    32'(err_cnt_f),     cexp(1));
    chk("ff_f_sticky", 32'(err_sticky_f),  1);
    chk("ff_d_drop",   32'(out_valid_d),   0);
    in_valid = 1'b0;
    tick();

    // Saturation of a 2-bit counter, then clear coincident with illegal code
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = sat_codes[i];
      tick();
      chk($sformatf("sat_cnt%0d", i), 32'(err_cnt_s), cexp(sat_exp[i]));
    end
    chk("sat_wide_cnt", 32'(err_cnt_d), cexp(5));
    in_data = 8'h55; err_clr = 1'b1;
    tick();
    err_clr = 1'b0; in_valid = 1'b0;
    chk("clrill_cnt",    32'(err_cnt_s),    cexp(1));
    chk("clrill_sticky", 32'(err_sticky_s), 1);
    chk("clrill_wide",   32'(err_cnt_d),    cexp(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr2_sticky", 32'(err_sticky_s), 0);
    chk("clr2_cnt",    32'(err_cnt_s),    0);
    tick();

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd0;
    tick();
    in_data = 8'd1;
    tick();
    in_valid = 1'b0;
    chk("full_rdy",   32'(in_ready_d),  0);
    chk("full_valid", 32'(out_valid_d), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_d), 0);
    chk("arst_rdy",   32'(in_ready_d),  1);
    chk("arst_data",  32'(out_data_d),  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_empty", 32'(out_valid_d), 0);
    in_valid = 1'b1; in_data = 8'd2;
    tick();
    chk("post_rst_valid", 32'(out_valid_d), 1);
    chk("post_rst_data",  32'(out_data_d),  2);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
